// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders + carry flop), LSB first, WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the sub port (a-b computed as a+~b+1).
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             op_sub;
    logic             s1, c1, s2, c2, cy_next;

`ifdef SERIAL_ADD_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    assign s1      = a_sh[0] ^ b_sh[0];
    assign c1      = a_sh[0] & b_sh[0];
    assign s2      = s1 ^ cy;
    assign c2      = s1 & cy;
    assign cy_next = c1 | c2;

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            a_sh      <= '0;
            b_sh      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        // Subtraction: invert b and seed the carry with 1.
                        b_sh  <= op_sub ? ~b : b;
                        cy    <= op_sub;
                        cnt   <= '0;
                        state <= StShift;
                    end
                end
                StShift: begin
                    sum  <= {s2, sum[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cy   <= cy_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastBit) begin
                        carry_out <= cy_next;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8): vector table plus hold, busy-ignore and reset cases.
module tb_bit_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for out_valid; leaves the result undrained.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        sub = xs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 0);
        chk("drain_in_ready", in_ready, 1);
        chk("drain_busy", busy, 0);
    endtask

    vec_t vecs[$];
    int   lat;
    logic [W-1:0] held;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;

        vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_carry", carry_out, 0);
        chk("rst_busy", busy, 0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            chk($sformatf("vec%0d_latency", i), lat, W);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
            chk($sformatf("vec%0d_carry", i), carry_out, vecs[i].exp_c);
            drain();
        end
        sub = 1'b0;

        // Result must hold while the consumer stalls.
        issue(8'hFF, 8'h01, 1'b0, lat);
        held = sum;
        chk("wrap_sum", sum, 8'h00);
        chk("wrap_carry", carry_out, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, held);
            chk("hold_carry", carry_out, 1);
        end
        drain();
        @(negedge clk);
        chk("idle_sum_held", sum, 8'h00);
        chk("idle_carry_held", carry_out, 1);

        // Operands offered while busy must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'hAA;
        lat = 3;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_ign_latency", lat, W);
        chk("busy_ign_sum", sum, 8'h30);
        chk("busy_ign_carry", carry_out, 0);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("busy_ign_no_accept", busy, 0);

        // Setup carry_out=1, then reset in the middle of the next op.
        issue(8'hC8, 8'h64, 1'b0, lat);
        chk("pre_rst_carry", carry_out, 1);
        drain();
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum, 8'h00);
        chk("mid_rst_carry", carry_out, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_rst_no_output", out_valid, 0);
        end
        issue(8'h02, 8'h03, 1'b0, lat);
        chk("post_rst_latency", lat, W);
        chk("post_rst_sum", sum, 8'h05);
        chk("post_rst_carry", carry_out, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
